// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and widths.
package bit_serial_adder_pkg;

  localparam int STATE_W = 2;

  // Code 2'd3 is never entered on purpose; the FSM recovers from it to IDLE.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_ADD     = 2'd1,
    S_DONE    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_e;

endpackage

// File: rtl/bit_serial_adder_fadder.sv
// One-bit full adder cell that the serial adder reuses once per clock.
module fadder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one fadder bit per clock, LSB first, with start/busy/done handshake.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-2:0] sh_s_q, sh_s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_cout;
  logic             last_bit;
  logic [WIDTH-1:0] sh_s_next;

  fadder u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  // Full sum register image after this bit; its low bit falls out of the shifter each cycle.
  assign sh_s_next = {fa_s, sh_s_q};

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sh_a_d  = a;
          sh_b_d  = b;
          sh_s_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
        sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
        sh_s_d  = sh_s_next[WIDTH-1:1];
        carry_d = fa_cout;
        if (last_bit) begin
          sum_d   = sh_s_next;
          cout_d  = fa_cout;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: vector table, random ops, back-to-back, reset abort, WIDTH=2 exhaustive.
module tb_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer addition widened by one bit.
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // One full WIDTH=8 operation with cycle-exact busy/done checks; inputs scrambled mid-op.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                               input logic [8:0] expv, input string tag);
    @(negedge clk);
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput({tag, " busy"}, 64'(busy8), 64'd1);
      checkOutput({tag, " done early"}, 64'(done8), 64'd0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    checkOutput({tag, " done"}, 64'(done8), 64'd1);
    checkOutput({tag, " busy at done"}, 64'(busy8), 64'd0);
    checkOutput({tag, " sum"}, 64'(sum8), 64'(expv[7:0]));
    checkOutput({tag, " cout"}, 64'(cout8), 64'(expv[8]));
    @(negedge clk);
    checkOutput({tag, " done pulse width"}, 64'(done8), 64'd0);
  endtask

  task automatic applyStimulus2(input logic [1:0] ta, input logic [1:0] tb_v, input logic tc);
    int lat;
    logic [2:0] expv;
    expv = 3'(ta) + 3'(tb_v) + 3'(tc);
    @(negedge clk);
    a2 = ta; b2 = tb_v; cin2 = tc; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("w2 latency", 64'(lat), 64'd3);
    checkOutput("w2 result", 64'({cout2, sum2}), 64'(expv));
  endtask

  initial begin
    logic [7:0] ra, rb, ra2, rb2;
    logic       rc, rc2;
    logic [8:0] expv, exp_b2b, last_res;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 64'(busy8), 64'd0);
    checkOutput("reset done", 64'(done8), 64'd0);
    checkOutput("reset sum", 64'(sum8), 64'd0);
    checkOutput("reset cout", 64'(cout8), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].exp_cout, vecs[i].exp_sum},
                    $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      applyStimulus(ra, rb, rc, model8(ra, rb, rc), $sformatf("rand%0d", i));
    end

    // start held high: no restart while busy, then back-to-back from DONE
    ra2 = 8'($urandom); rb2 = 8'($urandom); rc2 = 1'($urandom);
    exp_b2b = model8(ra2, rb2, rc2);
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checkOutput("held busy", 64'(busy8), 64'd1);
      checkOutput("held done early", 64'(done8), 64'd0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
    end
    checkOutput("held done", 64'(done8), 64'd1);
    checkOutput("held sum", 64'(sum8), 64'h96);
    checkOutput("held cout", 64'(cout8), 64'd0);
    a8 = ra2; b8 = rb2; cin8 = rc2;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("b2b busy", 64'(busy8), 64'd1);
      checkOutput("b2b sum hold", 64'(sum8), 64'h96);
      checkOutput("b2b done early", 64'(done8), 64'd0);
      @(negedge clk);
    end
    checkOutput("b2b done", 64'(done8), 64'd1);
    checkOutput("b2b result", 64'({cout8, sum8}), 64'(exp_b2b));
    last_res = exp_b2b;

    // quiet period after done: outputs must hold
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle hold result", 64'({cout8, sum8}), 64'(last_res));
      checkOutput("idle busy", 64'(busy8), 64'd0);
      checkOutput("idle done", 64'(done8), 64'd0);
    end

    // make sure the result registers are non-zero before the abort
    applyStimulus(8'h5A, 8'h3C, 1'b0, model8(8'h5A, 8'h3C, 1'b0), "pre-abort");
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort busy", 64'(busy8), 64'd0);
    checkOutput("abort done", 64'(done8), 64'd0);
    checkOutput("abort sum", 64'(sum8), 64'd0);
    checkOutput("abort cout", 64'(cout8), 64'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checkOutput("abort no done", 64'(done8), 64'd0);
      checkOutput("abort no busy", 64'(busy8), 64'd0);
    end

    for (int v = 0; v < 32; v++) begin
      expv = 9'(v);
      applyStimulus2(expv[4:3], expv[2:1], expv[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
